// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: parametrised synchronous FIFO controller driving an external read-first 1-cycle RAM
module fifo_sync_ctrl #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter int OUT_REG  = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_next;
  logic              wa, ra, v1;
  // a pop on a full FIFO frees the slot the simultaneous push lands in
  always_comb begin
    wa = push && (!full || pop) && !clear;
    ra = pop && !empty && !clear;
    level_next = clear ? '0 : level + (ADDR_W+1)'(wa) - (ADDR_W+1)'(ra);
  end
  assign mem_wr_en   = wa;
  assign mem_wr_addr = wr_ptr;
  assign mem_wr_data = wr_data;
  assign mem_rd_en   = ra;
  assign mem_rd_addr = rd_ptr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      v1           <= 1'b0;
    end else begin
      wr_ptr       <= clear ? '0 : wr_ptr + ADDR_W'(wa);
      rd_ptr       <= clear ? '0 : rd_ptr + ADDR_W'(ra);
      level        <= level_next;
      empty        <= level_next == '0;
      full         <= level_next == DEPTH_L;
      almost_empty <= level_next <= AE_L;
      almost_full  <= level_next >= AF_L;
      overflow     <= !clear && (overflow || (push && full && !pop));
      underflow    <= !clear && (underflow || (pop && empty));
      v1           <= ra;
    end
  if (OUT_REG != 0) begin : g_reg
    logic             v2;
    logic [WIDTH-1:0] dq;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        v2 <= 1'b0;
        dq <= '0;
      end else begin
        v2 <= v1 && !clear;
        if (v1) dq <= mem_rd_data;
      end
    assign rd_valid = v2;
    assign rd_data  = dq;
  end else begin : g_comb
    assign rd_valid = v1;
    assign rd_data  = v1 ? mem_rd_data : '0;
  end
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: scoreboard bench running OUT_REG=0 and OUT_REG=1 controllers side by side
module tb_fifo_sync_ctrl;
  localparam int W = 64;
  localparam int D = 8;
  logic clk = 0, reset_n = 0, clear = 0, push = 0, pop = 0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd0, rd1, mwd0, mwd1, mrd0, mrd1;
  logic rv0, rv1, em0, em1, fu0, fu1, ae0, ae1, af0, af1, ov0, ov1, un0, un1;
  logic mwe0, mwe1, mre0, mre1;
  logic [2:0] mwa0, mwa1, mra0, mra1;
  logic [3:0] lv0, lv1;
  logic [W-1:0] mem0 [D];
  logic [W-1:0] mem1 [D];
  logic [W-1:0] model[$], exp0[$], exp1[$];
  logic [W-1:0] e0, e1;
  logic ovf_m = 0, unf_m = 0;
  int tests = 0, fails = 0;
  logic [9:0] st0, st1, es;
  assign st0 = {em0, fu0, ae0, af0, ov0, un0, lv0};
  assign st1 = {em1, fu1, ae1, af1, ov1, un1, lv1};

  always #5 clk = ~clk;

  fifo_sync_ctrl #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(0)) u0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd0), .rd_valid(rv0), .empty(em0), .full(fu0), .almost_empty(ae0), .almost_full(af0),
    .level(lv0), .overflow(ov0), .underflow(un0), .mem_wr_en(mwe0), .mem_wr_addr(mwa0),
    .mem_wr_data(mwd0), .mem_rd_en(mre0), .mem_rd_addr(mra0), .mem_rd_data(mrd0));
  fifo_sync_ctrl #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(1)) u1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd1), .rd_valid(rv1), .empty(em1), .full(fu1), .almost_empty(ae1), .almost_full(af1),
    .level(lv1), .overflow(ov1), .underflow(un1), .mem_wr_en(mwe1), .mem_wr_addr(mwa1),
    .mem_wr_data(mwd1), .mem_rd_en(mre1), .mem_rd_addr(mra1), .mem_rd_data(mrd1));

  // read-first RAM macros
  always @(posedge clk) begin
    if (mre0) mrd0 <= mem0[mra0];
    if (mwe0) mem0[mwa0] <= mwd0;
    if (mre1) mrd1 <= mem1[mra1];
    if (mwe1) mem1[mwa1] <= mwd1;
  end

  always @(negedge clk) if (rv0) begin
    tests++;
    if (exp0.size() == 0) begin fails++; $display("FAIL rd0_spurious got=%h", rd0); end
    else begin
      e0 = exp0.pop_front();
      if (rd0 !== e0) begin fails++; $display("FAIL rd0_data got=%h exp=%h", rd0, e0); end
    end
  end
  always @(negedge clk) if (rv1) begin
    tests++;
    if (exp1.size() == 0) begin fails++; $display("FAIL rd1_spurious got=%h", rd1); end
    else begin
      e1 = exp1.pop_front();
      if (rd1 !== e1) begin fails++; $display("FAIL rd1_data got=%h exp=%h", rd1, e1); end
    end
  end

  function automatic logic [9:0] exp_st();
    int n = model.size();
    return {n == 0, n == D, n <= 1, n >= 6, ovf_m, unf_m, 4'(n)};
  endfunction

  task automatic cyc(input logic p, input logic q, input logic [W-1:0] d);
    int n;
    logic [W-1:0] x;
    n = model.size();
    push = p; pop = q; wr_data = d;
    ovf_m |= p && n == D && !q;
    unf_m |= q && n == 0;
    if (q && n > 0) begin x = model.pop_front(); exp0.push_back(x); exp1.push_back(x); end
    if (p && (n < D || q)) model.push_back(d);
    @(negedge clk);
    push = 0; pop = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({st0, st1} !== {2{10'b1010000000}} || {rv0, rv1, mwe0, mwe1, mre0, mre1} !== 6'b0 || rd1 !== '0 || rd0 !== '0) begin
      fails++; $display("FAIL reset st0=%h st1=%h rv=%b%b rd1=%h", st0, st1, rv0, rv1, rd1);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 2 * D; i++) begin
      if (i <= D) cyc(1, 0, W'(i)); else cyc(0, 1, '0);
      es = exp_st(); tests++;
      if (st0 !== es || st1 !== es) begin fails++; $display("FAIL fill_drain step=%0d st0=%h st1=%h exp=%h", i, st0, st1, es); end
    end
    repeat (2) cyc(0, 0, '0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) cyc(1, 0, W'(32'h100 + i));
    cyc(1, 0, W'(32'hDEAD));
    es = exp_st(); tests++;
    if (st0 !== es || st1 !== es) begin fails++; $display("FAIL overflow st0=%h st1=%h exp=%h", st0, st1, es); end
    for (int i = 0; i < D; i++) cyc(0, 1, '0);
    repeat (2) cyc(0, 0, '0);
    cyc(0, 1, '0);
    es = exp_st(); tests++;
    if (st0 !== es || st1 !== es) begin fails++; $display("FAIL underflow st0=%h st1=%h exp=%h", st0, st1, es); end
    cyc(1, 1, W'(32'h77));
    es = exp_st(); tests++;
    if (st0 !== es || st1 !== es) begin fails++; $display("FAIL pop_empty_push st0=%h st1=%h exp=%h", st0, st1, es); end
    cyc(0, 1, '0);
    repeat (2) cyc(0, 0, '0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= D; i++) cyc(1, 0, W'(i));
    for (int i = 0; i < 13; i++) begin
      cyc(1, 1, W'(9 + i));
      es = exp_st(); tests++;
      if (st0 !== es || st1 !== es) begin fails++; $display("FAIL full_pp step=%0d st0=%h st1=%h exp=%h", i, st0, st1, es); end
    end
    for (int i = 0; i < D; i++) cyc(0, 1, '0);
    repeat (2) cyc(0, 0, '0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(32'hC0 + i));
    cyc(0, 1, '0);
    #1;
    clear = 1; push = 1; pop = 1; wr_data = W'(32'hBAD);
    #1;
    tests++;
    if ({mwe0, mwe1, mre0, mre1} !== 4'b0) begin fails++; $display("FAIL clear_mem_en got=%b exp=0000", {mwe0, mwe1, mre0, mre1}); end
    exp1.delete(); model.delete(); ovf_m = 0; unf_m = 0;
    @(negedge clk);
    clear = 0; push = 0; pop = 0;
    es = exp_st(); tests++;
    if (st0 !== es || st1 !== es) begin fails++; $display("FAIL clear st0=%h st1=%h exp=%h", st0, st1, es); end
    repeat (2) cyc(0, 0, '0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) cyc(1, 0, W'(32'hA0 + i));
    cyc(1, 1, W'(32'hA6));
    pop = 1;
    e0 = model.pop_front(); exp0.push_back(e0); exp1.push_back(e0);
    @(posedge clk); #2;
    reset_n = 0;
    #1;
    exp0.delete(); exp1.delete(); model.delete(); ovf_m = 0; unf_m = 0;
    tests++;
    if ({st0, st1} !== {2{10'b1010000000}} || {rv0, rv1} !== 2'b0 || rd0 !== '0 || rd1 !== '0) begin
      fails++; $display("FAIL reset_mid st0=%h st1=%h rv=%b%b", st0, st1, rv0, rv1);
    end
    pop = 0;
    @(negedge clk);
    reset_n = 1;
    cyc(1, 0, W'(32'hBEEF));
    cyc(0, 1, '0);
    repeat (2) cyc(0, 0, '0);
    es = exp_st(); tests++;
    if (st0 !== es || st1 !== es) begin fails++; $display("FAIL after_reset st0=%h st1=%h exp=%h", st0, st1, es); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_reset_mid();
    repeat (3) cyc(0, 0, '0);
    tests++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      fails++; $display("FAIL drain pending0=%0d pending1=%0d exp=0", exp0.size(), exp1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
